// File: rtl/viol_reset_seq.sv
// viol_reset_seq: turns monitor reset requests into a fixed-length core reset pulse and logs
// sticky causes plus a saturating violation count. Optional permanent lockout: VIOL_LOCKOUT_EN.
module viol_reset_seq #(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned LOCK_THRESH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] viol_in,
   input  logic               cause_clr,
   output logic               sys_rst,
   output logic               rst_pending,
   output logic [NUM_SRC-1:0] cause,
   output logic [CNT_W-1:0]   viol_cnt,
   output logic               locked
);

   localparam int unsigned HOLD_W = 8;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_hold_chk
      $error("viol_reset_seq: HOLD_CYCLES must be 1..255");
   end
   if (LOCK_THRESH < 1) begin : g_lock_chk
      $error("viol_reset_seq: LOCK_THRESH must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_RUN,
      ST_ASSERT,
      ST_RELEASE
   } state_e;

   state_e             state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [NUM_SRC-1:0] viol_q;
   logic [NUM_SRC-1:0] cause_q, cause_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sys_rst_q, sys_rst_d;
   logic               pend_q, pend_d;
   logic [NUM_SRC-1:0] edge_c;
   logic               event_c;

   assign edge_c  = viol_in & ~viol_q;
   assign event_c = |edge_c;

   // Cause/count logging; a clear coinciding with an event keeps that event.
   always_comb begin
      cause_d = cause_q;
      cnt_d   = cnt_q;
      if (cause_clr) begin
         cause_d = '0;
         cnt_d   = '0;
      end
      if (event_c) begin
         cause_d = cause_d | edge_c;
         if (cnt_d != '1) begin
            cnt_d = cnt_d + CNT_W'(1);
         end
      end
   end

`ifdef VIOL_LOCKOUT_EN
   logic locked_q, locked_d;

   assign locked_d = locked_q | (event_c && (32'(cnt_d) >= LOCK_THRESH));
   assign locked   = locked_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= locked_d;
      end
   end
`else
   assign locked = 1'b0;
`endif

   // Next-state logic; outputs are derived from the next state and registered.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         ST_RUN: begin
            if (event_c) begin
               state_d = ST_ASSERT;
               hold_d  = '0;
            end
         end
         ST_ASSERT: begin
            if (event_c) begin
               hold_d = '0;
            end else if (hold_q == HOLD_LAST) begin
               state_d = ST_RELEASE;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         ST_RELEASE: begin
            if (event_c) begin
               state_d = ST_ASSERT;
               hold_d  = '0;
            end else if (viol_in == '0) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_ASSERT;
            hold_d  = '0;
         end
      endcase
`ifdef VIOL_LOCKOUT_EN
      if (locked_d) begin
         state_d = ST_ASSERT;
         hold_d  = '0;
      end
`endif
      sys_rst_d = (state_d == ST_ASSERT);
      pend_d    = (state_d != ST_RUN);
   end

   // Reset parks viol_q at all ones so requests already high at power-up are not events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ASSERT;
         hold_q    <= '0;
         viol_q    <= '1;
         cause_q   <= '0;
         cnt_q     <= '0;
         sys_rst_q <= 1'b1;
         pend_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         viol_q    <= viol_in;
         cause_q   <= cause_d;
         cnt_q     <= cnt_d;
         sys_rst_q <= sys_rst_d;
         pend_q    <= pend_d;
      end
   end

   assign sys_rst     = sys_rst_q;
   assign rst_pending = pend_q;
   assign cause       = cause_q;
   assign viol_cnt    = cnt_q;

endmodule

// File: tb/tb_viol_reset_seq.sv
// Bench for viol_reset_seq: directed plan steps plus random requests against a pulse-budget model.
module tb_viol_reset_seq;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned HOLD    = 8;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned LOCK    = 16;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NUM_SRC-1:0] viol_in;
   logic               cause_clr;
   logic               sys_rst;
   logic               rst_pending;
   logic [NUM_SRC-1:0] cause;
   logic [CNT_W-1:0]   viol_cnt;
   logic               locked;

   always #5 clk = ~clk;

   viol_reset_seq #(
      .NUM_SRC    (NUM_SRC),
      .HOLD_CYCLES(HOLD),
      .CNT_W      (CNT_W),
      .LOCK_THRESH(LOCK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .viol_in    (viol_in),
      .cause_clr  (cause_clr),
      .sys_rst    (sys_rst),
      .rst_pending(rst_pending),
      .cause      (cause),
      .viol_cnt   (viol_cnt),
      .locked     (locked)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: remaining reset-pulse cycles, a "waiting for monitors" flag, lock flag, log state.
   int                 m_left;
   bit                 m_pend;
   bit                 m_lock;
   logic [NUM_SRC-1:0] m_prev;
   logic [NUM_SRC-1:0] m_cause;
   int                 m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_left  = HOLD;
      m_pend  = 1'b1;
      m_lock  = 1'b0;
      m_prev  = '1;
      m_cause = '0;
      m_cnt   = 0;
   endtask

   task automatic model_clock(input logic [NUM_SRC-1:0] vin, input logic clr);
      logic [NUM_SRC-1:0] e;
      e      = vin & ~m_prev;
      m_prev = vin;
      if (clr) begin
         m_cause = '0;
         m_cnt   = 0;
      end
      if (e != '0) begin
         m_cause = m_cause | e;
         if (m_cnt < CNT_MAX) m_cnt++;
`ifdef VIOL_LOCKOUT_EN
         if (m_cnt >= LOCK) m_lock = 1'b1;
`endif
         m_left = HOLD;
         m_pend = 1'b1;
      end else if (m_left > 0) begin
         m_left--;
      end else if (m_pend && vin == '0) begin
         m_pend = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".sys_rst"},  32'(sys_rst),     32'(m_lock || m_left > 0));
      chk({tag, ".pending"},  32'(rst_pending), 32'(m_lock || m_pend));
      chk({tag, ".cause"},    32'(cause),       32'(m_cause));
      chk({tag, ".viol_cnt"}, 32'(viol_cnt),    32'(m_cnt));
      chk({tag, ".locked"},   32'(locked),      32'(m_lock));
   endtask

   task automatic step(input string tag, input logic [NUM_SRC-1:0] vin, input logic clr);
      viol_in   = vin;
      cause_clr = clr;
      @(posedge clk);
      model_clock(vin, clr);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset asserted between clock edges, checked before any edge arrives.
   task automatic do_reset(input string tag, input logic [NUM_SRC-1:0] vin);
      viol_in   = vin;
      cause_clr = 1'b0;
      rst_n     = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1;
      check_all(tag);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NUM_SRC-1:0] v;
      logic               c;

      // Power-up with DMA/IRQ request already high
      rst_n     = 1'b0;
      viol_in   = 4'b0001;
      cause_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.sys_rst_hi", 32'(sys_rst), 32'd1);
      rst_n = 1'b1;
      repeat (12) step("pwrup", 4'b0001, 1'b0);
      chk("pwrup.held_release", 32'(rst_pending), 32'd1);
      repeat (2) step("pwrup_drop", 4'b0000, 1'b0);
      chk("pwrup.run", 32'(rst_pending), 32'd0);

      // Single rise from RUN, drop after 12 cycles
      repeat (12) step("rise0", 4'b0001, 1'b0);
      chk("rise0.cause", 32'(cause), 32'h1);
      chk("rise0.cnt", 32'(viol_cnt), 32'd1);
      repeat (2) step("rise0_drop", 4'b0000, 1'b0);

      // Second source rises mid-pulse and re-arms the hold
      repeat (6) step("rearm_a", 4'b0001, 1'b0);
      repeat (10) step("rearm_b", 4'b0101, 1'b0);
      chk("rearm.cause", 32'(cause), 32'h5);
      chk("rearm.cnt", 32'(viol_cnt), 32'd3);
      repeat (2) step("rearm_drop", 4'b0000, 1'b0);

      // Rise during RELEASE, then clear coinciding with a new edge
      repeat (10) step("rel_a", 4'b0001, 1'b0);
      step("rel_b", 4'b0011, 1'b0);
      chk("rel.back_to_assert", 32'(sys_rst), 32'd1);
      repeat (10) step("rel_c", 4'b0011, 1'b0);
      step("clr_edge", 4'b1011, 1'b1);
      chk("clr_edge.cause", 32'(cause), 32'h8);
      chk("clr_edge.cnt", 32'(viol_cnt), 32'd1);
      repeat (10) step("clr_tail", 4'b0000, 1'b0);

      // Random requests, clears and a mid-pulse async reset
      for (int i = 0; i < 400; i++) begin
         v = viol_in;
         if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) v = 4'b0000;
         c = ($urandom_range(0, 19) == 0);
         step("rand", v, c);
         if (i == 200) do_reset("midrst", 4'($urandom_range(0, 15)));
      end
      repeat (12) step("rand_drain", 4'b0000, 1'b0);

`ifdef VIOL_LOCKOUT_EN
      do_reset("lk_rst", 4'b0000);
      repeat (10) step("lk_settle", 4'b0000, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step("lk_ev", 4'b0010, 1'b0);
         step("lk_ev", 4'b0000, 1'b0);
      end
      chk("lk.locked", 32'(locked), 32'd1);
      for (int i = 0; i < 100; i++) begin
         step("lk_hold", 4'($urandom_range(0, 15)), (i == 50));
      end
      chk("lk.sys_rst", 32'(sys_rst), 32'd1);
      chk("lk.still_locked", 32'(locked), 32'd1);
      do_reset("lk_exit", 4'b0000);
      chk("lk_exit.locked", 32'(locked), 32'd0);
      chk("lk_exit.cnt", 32'(viol_cnt), 32'd0);
`else
      // Saturation: 300 distinct events
      step("sat_clr", 4'b0000, 1'b1);
      for (int i = 0; i < 300; i++) begin
         step("sat", 4'b0001, 1'b0);
         step("sat", 4'b0000, 1'b0);
      end
      chk("sat.cnt", 32'(viol_cnt), 32'd255);
      chk("sat.locked", 32'(locked), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
